// File: rtl/OoO_pkg.sv
// Shared types for the decode/dispatch front end.
// Provides the decoded-instruction payload (decoder_t), the functional-unit
// and operation encodings, the dispatch FIFO entry and the dispatch FSM states.
package OoO_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned IMM_W = 32;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_LOAD,
        FU_STORE,
        FU_CTRL,
        FU_CSR
    } fu_t;

    typedef enum logic [4:0] {
        ADD,
        ADDI,
        SUB,
        LW,
        SW,
        BEQ,
        JAL,
        CSR_RW,
        CSR_RS,
        CSR_RC,
        ECALL,
        EBREAK,
        MRET,
        CF_FENCE,
        CF_FENCE_I
    } op_t;

    typedef struct packed {
        fu_t              fu;
        op_t              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } decoder_t;

    // One buffered decoder output: instruction plus its illegal flag.
    typedef struct packed {
        decoder_t instr;
        logic     err;
    } dispatch_entry_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WAIT
    } dispatch_state_e;

endpackage

// File: rtl/dispatch_fifo.sv
// Small circular FIFO with a registered occupancy count.
// Ports: clk_i/rst_ni (async active-low), flush_i (empties the queue),
//        push_valid_i/push_ready_o/push_data_i (write side),
//        pop_valid_o/pop_ready_i/pop_data_o (read side, head entry).
// A pop in a full cycle does not open space for a same-cycle push.
module dispatch_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_valid_i,
    output logic push_ready_o,
    input  T     push_data_i,
    output logic pop_valid_o,
    input  logic pop_ready_i,
    output T     pop_data_o
);

    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CNT_W = $clog2(Depth + 1);

    T                 r_mem [Depth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign push_ready_o = (r_count < CNT_W'(Depth));
    assign pop_valid_o  = (r_count != '0);
    assign pop_data_o   = r_mem[r_rd_ptr];
    assign w_push       = push_valid_i && push_ready_o;
    assign w_pop        = pop_valid_o && pop_ready_i;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/id_dispatch_ctrl.sv
// Decode-to-issue sequencer. Buffers decoded instructions and forwards
// ordinary ones back-to-back; serializing ones (CSR/system, FENCE, FENCE_I,
// illegal) wait for an empty ROB, then block dispatch until commit reports
// completion. A completed FENCE_I produces a one-cycle fetch-flush pulse.
// Ports: clk_i, rst_ni (async active-low), flush_i,
//        dec_valid_i/dec_ready_o/dec_instr_i/dec_err_i (decoder side),
//        iss_valid_o/iss_ready_i/iss_instr_o/iss_err_o (issue side),
//        rob_empty_i, serial_done_i, fencei_o (pulse), busy_o (not in RUN).
module id_dispatch_ctrl
    import OoO_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush_i,
    input  logic     dec_valid_i,
    output logic     dec_ready_o,
    input  decoder_t dec_instr_i,
    input  logic     dec_err_i,
    output logic     iss_valid_o,
    input  logic     iss_ready_i,
    output decoder_t iss_instr_o,
    output logic     iss_err_o,
    input  logic     rob_empty_i,
    input  logic     serial_done_i,
    output logic     fencei_o,
    output logic     busy_o
);

    if (Depth < 2) begin : g_depth_check
        $error("id_dispatch_ctrl: Depth must be at least 2");
    end

    dispatch_state_e r_state;
    dispatch_state_e w_state_d;
    logic            r_is_fencei;
    logic            w_is_fencei_d;

    logic            w_fifo_ready;
    logic            w_fifo_valid;
    dispatch_entry_t w_push_entry;
    dispatch_entry_t w_head;
    logic            w_head_serial;
    logic            w_issue;

    assign w_push_entry = '{instr: dec_instr_i, err: dec_err_i};
    assign dec_ready_o  = w_fifo_ready && !flush_i;
    assign iss_instr_o  = w_head.instr;
    assign iss_err_o    = w_head.err;
    assign w_issue      = iss_valid_o && iss_ready_i;
    assign busy_o       = (r_state != RUN);

    dispatch_fifo #(
        .T     (dispatch_entry_t),
        .Depth (Depth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_valid_i (dec_valid_i && !flush_i),
        .push_ready_o (w_fifo_ready),
        .push_data_i  (w_push_entry),
        .pop_valid_o  (w_fifo_valid),
        .pop_ready_i  (w_issue),
        .pop_data_o   (w_head)
    );

    // Head needs the ROB drained first (system ops are encoded as FU_CSR).
    assign w_head_serial = (w_head.instr.fu == FU_CSR)
                        || (w_head.instr.op == CF_FENCE)
                        || (w_head.instr.op == CF_FENCE_I)
                        || w_head.err;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RUN;
            r_is_fencei <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_is_fencei <= w_is_fencei_d;
        end
    end

    // Next-state and issue/pulse decode; flush overrides everything.
    always_comb begin
        w_state_d     = r_state;
        w_is_fencei_d = r_is_fencei;
        iss_valid_o   = 1'b0;
        fencei_o      = 1'b0;

        case (r_state)
            RUN: begin
                if (w_fifo_valid) begin
                    if (w_head_serial) begin
                        w_state_d = DRAIN;
                    end else begin
                        iss_valid_o = 1'b1;
                    end
                end
            end
            DRAIN: begin
                iss_valid_o = rob_empty_i && w_fifo_valid;
                if (iss_valid_o && iss_ready_i) begin
                    w_state_d     = WAIT;
                    w_is_fencei_d = (w_head.instr.op == CF_FENCE_I);
                end
            end
            WAIT: begin
                if (serial_done_i) begin
                    w_state_d     = RUN;
                    fencei_o      = r_is_fencei;
                    w_is_fencei_d = 1'b0;
                end
            end
            default: begin
                w_state_d = RUN;
            end
        endcase

        if (flush_i) begin
            w_state_d     = RUN;
            w_is_fencei_d = 1'b0;
            iss_valid_o   = 1'b0;
            fencei_o      = 1'b0;
        end
    end

endmodule

// File: doc/id_dispatch_ctrl.md
# id_dispatch_ctrl

Sequencer between the RV32 decoder and the issue stage. It buffers decoded instructions in a small FIFO and forwards ordinary ones back-to-back. Serializing instructions (CSR access, ECALL/MRET/EBREAK, FENCE, FENCE_I, illegal) are held until the ROB drains. After one issues, further dispatch is blocked until commit signals completion. FENCE_I completion is converted into a fetch-flush pulse.

## Interface
Parameters:
- Depth, 2, FIFO entries; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush (mispredict/exception).
- dec_valid_i  in  1  decoder output valid.
- dec_ready_o  out  1  block can accept an entry.
- dec_instr_i  in  decoder_t  decoded instruction.
- dec_err_i  in  1  decoder illegal-instruction flag.
- iss_valid_o  out  1  entry presented to issue.
- iss_ready_i  in  1  issue accepts.
- iss_instr_o  out  decoder_t  head entry.
- iss_err_o  out  1  head entry's error flag.
- rob_empty_i  in  1  no uncommitted instructions in flight.
- serial_done_i  in  1  serializing instruction has committed or trapped.
- fencei_o  out  1  one-cycle pulse requesting a fetch/icache flush.
- busy_o  out  1  FSM is not in RUN.

## Operation
- Serializing head: any of fu==FU_CSR; op==CF_FENCE; op==CF_FENCE_I; iss_err_o=1.
- FIFO: push on dec_valid_i&&dec_ready_o, storing {dec_instr_i, dec_err_i}. Pop on iss_valid_o&&iss_ready_i. Pointers wrap modulo Depth.
- dec_ready_o = (count<Depth) && !flush_i.
- FSM states and transitions:
  - RUN: if the FIFO is non-empty and the head is non-serializing, iss_valid_o=1. If the head is serializing, iss_valid_o=0 and the FSM moves to DRAIN.
  - DRAIN: iss_valid_o=rob_empty_i. On handshake, the FSM moves to WAIT and latches is_fencei from the head.
  - WAIT: iss_valid_o=0. Pushes continue while the FIFO is not full. On serial_done_i the FSM moves to RUN, and fencei_o=1 in that same cycle if is_fencei is set.
- Flush:
  - flush_i has priority over every other event.
  - In the flush cycle, iss_valid_o=0, dec_ready_o=0, and fencei_o=0.
  - Next cycle: count=0, state=RUN, is_fencei=0.
- serial_done_i outside WAIT is ignored.
- busy_o = (state!=RUN).

## Timing
- Reset values:
  - count=0, state=RUN, is_fencei=0, storage='0.
  - dec_ready_o=1, iss_valid_o=0, iss_instr_o='0, iss_err_o=0, fencei_o=0, busy_o=0.
- Latency:
  - Ordinary instructions: issue presentation at earliest 1 cycle after push. There is no bypass.
  - Sustained throughput: 1 instruction/cycle.
- Serializing instruction:
  - At the head in RUN → at least 1 bubble (DRAIN entry).
  - Earliest issue is the DRAIN cycle with rob_empty_i=1.
  - rob_empty_i must reflect an instruction issued in the previous cycle.
- Full FIFO: dec_ready_o=0. A pop in that cycle does not permit a same-cycle push; ready rises the following cycle.
- Empty FIFO: iss_valid_o=0 in every state.
- Handshake: once iss_valid_o=1, iss_instr_o stays stable until accepted or flushed.
- fencei_o is exactly one cycle, combinational on WAIT&&serial_done_i&&is_fencei&&!flush_i.

## Structure
- OoO_pkg supplies decoder_t, FU_CSR, CF_FENCE and CF_FENCE_I.
- Add dispatch_state_e {RUN, DRAIN, WAIT} to OoO_pkg.
- Sub-module dispatch_fifo: parameterized type and depth, with registered count and valid/ready on both sides.
- Serializing detection and the FSM live in the top module.

## Test plan
- Back-to-back: 4 ADDI pushed on consecutive cycles with iss_ready_i=1 → issued at cycles 1–4 in order; dec_ready_o stays 1.
- Backpressure: iss_ready_i=0, 3 pushes attempted → 2 accepted, dec_ready_o=0 from cycle 2. Release → entries issue in order, then ready=1.
- CSRRW, rob_empty_i=0 for 5 cycles → busy_o=1, no issue. rob_empty_i=1 → single issue. An ADDI behind it issues only in the cycle after serial_done_i.
- FENCE_I: issue, then serial_done_i at cycle 10 → fencei_o=1 only at cycle 10, state=RUN at cycle 11.
- Illegal entry (dec_err_i=1) → treated as serializing; iss_err_o=1 on issue.
- flush_i in WAIT with 2 queued entries → next cycle count=0, busy_o=0, iss_valid_o=0, no fencei_o. Asserting rst_ni low mid-DRAIN → all outputs immediately at reset values.
